// File: rtl/fault_sim_ctrl.sv
`default_nettype none
// ============================================================================
// fault_sim_ctrl : bit-parallel stuck-at fault simulation sequencer (a,b,c,d->f)
// Revision 1.0
// ============================================================================
module fault_sim_ctrl #(
  parameter int CNT_W         = 8,
  parameter int PATTERN_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [17:0]      fault_en_i,
  input  logic             pat_valid_i,
  input  logic [3:0]       pat_data_i,
  input  logic             pat_last_i,
  output logic             pat_ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [17:0]      det_mask_o,
  output logic [4:0]       det_count_o,
  output logic [CNT_W-1:0] pat_cnt_o,
  output logic             all_det_o
);

  localparam int unsigned NET_A  = 0;
  localparam int unsigned NET_B  = 1;
  localparam int unsigned NET_C  = 2;
  localparam int unsigned NET_D  = 3;
  localparam int unsigned NET_W1 = 4;
  localparam int unsigned NET_W2 = 5;
  localparam int unsigned NET_W3 = 6;
  localparam int unsigned NET_W4 = 7;
  localparam int unsigned NET_F  = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_EVAL   = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [17:0]      en_q, en_d;
  logic [3:0]       pat_q, pat_d;
  logic             last_q, last_d;
  logic [18:0]      f_word_q, f_word_d;
  logic [17:0]      det_mask_q, det_mask_d;
  logic [4:0]       det_count_q, det_count_d;
  logic [CNT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic             all_det_q, all_det_d;
  logic             pat_ready_q, busy_q, done_q;

  logic [17:0]      upd_mask;
  logic [CNT_W-1:0] upd_cnt;
  logic             upd_all;

  logic [18:0]      net_a, net_b, net_c, net_d;
  logic [18:0]      net_w1, net_w2, net_w3, net_w4;

  // Net n is stuck-at-0 in machine bit 2n+1 and stuck-at-1 in machine bit 2n+2.
  function automatic logic [18:0] inject(input logic [18:0] w, input int unsigned net);
    logic [18:0] sa0;
    logic [18:0] sa1;
    sa0 = 19'd1 << (2 * net + 1);
    sa1 = 19'd1 << (2 * net + 2);
    return (w & ~sa0) | sa1;
  endfunction

  function automatic logic [4:0] popcount18(input logic [17:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 18; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  always_comb begin
    net_a    = inject({19{pat_q[3]}}, NET_A);
    net_b    = inject({19{pat_q[2]}}, NET_B);
    net_c    = inject({19{pat_q[1]}}, NET_C);
    net_d    = inject({19{pat_q[0]}}, NET_D);
    net_w1   = inject(net_a ^ net_b, NET_W1);
    net_w2   = inject(net_w1 | net_c, NET_W2);
    net_w3   = inject(net_d & net_w1, NET_W3);
    net_w4   = inject(net_w2, NET_W4);
    f_word_d = inject(net_w3 | net_w4, NET_F);
  end

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    pat_d       = pat_q;
    last_d      = last_q;
    det_mask_d  = det_mask_q;
    det_count_d = det_count_q;
    pat_cnt_d   = pat_cnt_q;
    all_det_d   = all_det_q;

    // A fault is detected when its machine's f differs from the good machine.
    upd_mask = det_mask_q | ((f_word_q[18:1] ^ {18{f_word_q[0]}}) & en_q);
    upd_cnt  = pat_cnt_q + CNT_W'(1);
    upd_all  = ((upd_mask & en_q) == en_q);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          en_d        = fault_en_i;
          det_mask_d  = '0;
          det_count_d = '0;
          pat_cnt_d   = '0;
          all_det_d   = 1'b0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        if (pat_valid_i) begin
          pat_d   = pat_data_i;
          last_d  = pat_last_i;
          state_d = S_EVAL;
        end
      end
      S_EVAL: state_d = S_UPDATE;
      S_UPDATE: begin
        det_mask_d  = upd_mask;
        det_count_d = popcount18(upd_mask);
        pat_cnt_d   = upd_cnt;
        all_det_d   = upd_all;
        if (last_q || upd_all || (upd_cnt == CNT_W'(PATTERN_LIMIT))) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      en_q        <= '0;
      pat_q       <= '0;
      last_q      <= 1'b0;
      f_word_q    <= '0;
      det_mask_q  <= '0;
      det_count_q <= '0;
      pat_cnt_q   <= '0;
      all_det_q   <= 1'b0;
      pat_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      pat_q       <= pat_d;
      last_q      <= last_d;
      if (state_q == S_EVAL) begin
        f_word_q <= f_word_d;
      end
      det_mask_q  <= det_mask_d;
      det_count_q <= det_count_d;
      pat_cnt_q   <= pat_cnt_d;
      all_det_q   <= all_det_d;
      pat_ready_q <= (state_d == S_LOAD);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign pat_ready_o = pat_ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign det_mask_o  = det_mask_q;
  assign det_count_o = det_count_q;
  assign pat_cnt_o   = pat_cnt_q;
  assign all_det_o   = all_det_q;

endmodule
`default_nettype wire

// File: doc/fault_sim_ctrl.md
# fault_sim_ctrl

Sequencer for bit-parallel stuck-at fault simulation of the 4-input combinational test circuit (a, b, c, d -> f). It accepts input patterns over a valid/ready stream and evaluates one good machine plus 18 faulty machines in parallel per pattern. It accumulates a detected-fault mask, drops simulation once every enabled fault is detected or the pattern limit is hit, and reports coverage to the host.

## Interface
- CNT_W, 8: width of pattern counter.
- PATTERN_LIMIT, 255: max patterns consumed per run (must be <= 2^CNT_W-1).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run (honoured only in IDLE).
- fault_en  in  18  per-fault enable mask, sampled on start.
- pat_valid  in  1  pattern available.
- pat_data  in  4  pattern {a,b,c,d}, bit3=a, bit0=d.
- pat_last  in  1  final pattern of stream, qualified by pat_valid.
- pat_ready  out  1  controller accepts a pattern.
- busy  out  1  run in progress.
- done  out  1  one-cycle end-of-run pulse.
- det_mask  out  18  sticky detected faults.
- det_count  out  5  popcount of det_mask.
- pat_cnt  out  CNT_W  patterns consumed this run.
- all_det  out  1  (det_mask & en_reg) == en_reg.

## Operation
- Nets indexed a=0, b=1, c=2, d=3, w1=4, w2=5, w3=6, w4=7, f=8. Fault k = 2*net + v, with v=0 for SA0 and v=1 for SA1. w4 is a distinct fault site from w2.
- Circuit: w1=a^b, w2=w1|c, w3=d&w1, w4=w2, f=w3|w4.
- Machine word is 19 bits: bit0 is the good machine, bit k+1 is fault k. Each net is forced to 0 or 1 only in its own fault's bit.
- Only faults enabled in en_reg can be set in det_mask.
- States:
  - IDLE: pat_ready=0. On start: en_reg<=fault_en, det_mask<=0, pat_cnt<=0, go LOAD.
  - LOAD: pat_ready=1. On pat_valid: capture pat_data into pat_reg and pat_last into last_reg, go EVAL.
  - EVAL: compute the 19-bit f word from pat_reg and register it in f_word, go UPDATE.
  - UPDATE: det_mask |= (f_word[18:1] ^ {18{f_word[0]}}) & en_reg, pat_cnt++. Go DONE if last_reg, or the new all_det is 1, or pat_cnt reaches PATTERN_LIMIT; otherwise go LOAD.
  - DONE: done=1 for one cycle, then IDLE.
- busy=1 in LOAD, EVAL, UPDATE and DONE.
- Results (det_mask, det_count, pat_cnt, all_det) hold in IDLE until the next start.
- start outside IDLE is ignored.
- fault_en=0: all_det is 1 after the first UPDATE, so the run ends after one pattern.
- Early drop: after termination pat_ready stays 0, and unconsumed patterns remain on the stream.

## Timing
- Reset values: pat_ready=0, busy=0, done=0, det_mask=0, det_count=0, pat_cnt=0, all_det=0, state IDLE.
- Reset asserted mid-run aborts immediately to these values. No done pulse is issued.
- start to pat_ready is 1 cycle.
- Each pattern takes 3 cycles (LOAD handshake, EVAL, UPDATE), so peak throughput is 1 pattern per 3 cycles.
- det_mask, det_count and pat_cnt update at the end of UPDATE.
- done rises 1 cycle after the final UPDATE.
- pat_ready is registered and falls the cycle after the accepting handshake.
- pat_data and pat_last are ignored when pat_valid=0 or pat_ready=0.

## Test plan
- Reset, start with fault_en=3FFFF, pattern 0000 with pat_last=1 -> det_mask=0x2AA2A, det_count=8, pat_cnt=1, single done pulse, all_det=0.
- fault_en=3FFFF, exhaustive patterns 0..15 with pat_last on 15 -> det_mask=0x3EF3F, det_count=15 (d SA0, d SA1, w3 SA0 redundant), pat_cnt=16.
- fault_en=0x3EF3F, stream 0..15 -> all_det=1 and done after pattern 8 (1000), pat_cnt=9, pat_ready never reasserts.
- PATTERN_LIMIT=4, fault_en=3FFFF, stream 0..15 -> stops at pat_cnt=4, det_count=12.
- Assert rst during EVAL of the third pattern -> all outputs zero next edge, no done pulse. A new start then runs cleanly from zero counts.
- Hold pat_valid low for 5 cycles in LOAD, and pulse start mid-run -> state holds in LOAD, start ignored, results unchanged versus the uninterrupted run.
